cv32e40p_div_arbiter: RTL

Sequencing and sharing controller for the serial divider (`cv32e40p_alu_div`). Two requesters (e.g. two issue ports or a core ALU plus a debug/test port) present divide or remainder operations with a valid/ready handshake. The block arbitrates between them round-robin and computes the divider's side-band operands (shift amount, zero flag, sign). It issues one operation at a time, captures the result and returns it to the owning requester. It sits between the requesters and a single divider instance and owns that instance's handshake entirely.

---
 rtl/cv32e40p_div_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_div_arbiter.sv
// Round-robin sharing front end for a single serial divider: grants one of two
// requesters, precomputes divisor side-band values and returns the result.
// Optional DIV_ARB_ZERO_BYPASS_EN answers zero-divisor operations without the divider.
module cv32e40p_div_arbiter #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RBI,
    input  logic [1:0]             ReqVld_SI,
    output logic [1:0]             ReqRdy_SO,
    input  logic [2*C_WIDTH-1:0]   ReqOpA_DI,
    input  logic [2*C_WIDTH-1:0]   ReqOpB_DI,
    input  logic [3:0]             ReqOpCode_DI,
    output logic [1:0]             RspVld_SO,
    input  logic [1:0]             RspRdy_SI,
    output logic [C_WIDTH-1:0]     RspRes_DO,
    output logic                   Busy_SO,
    output logic [C_WIDTH-1:0]     Div_OpA_DO,
    output logic [C_WIDTH-1:0]     Div_OpB_DO,
    output logic [C_LOG_WIDTH-1:0] Div_OpBShift_DO,
    output logic                   Div_OpBIsZero_SO,
    output logic                   Div_OpBSign_SO,
    output logic [1:0]             Div_OpCode_SO,
    output logic                   Div_InVld_SO,
    output logic                   Div_OutRdy_SO,
    input  logic                   Div_OutVld_SI,
    input  logic [C_WIDTH-1:0]     Div_Res_DI
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t                 state_reg, state_next;
    logic                   prio_reg, prio_next;
    logic                   owner_reg, owner_next;
    logic [C_WIDTH-1:0]     op_a_reg, op_a_next;
    logic [C_WIDTH-1:0]     op_b_reg, op_b_next;
    logic [C_WIDTH-1:0]     res_reg, res_next;
    logic [C_LOG_WIDTH-1:0] shift_reg, shift_next;
    logic                   zero_reg, zero_next;
    logic                   sign_reg, sign_next;
    logic [1:0]             code_reg, code_next;

    logic [C_WIDTH-1:0] req_op_a [2];
    logic [C_WIDTH-1:0] req_op_b [2];
    logic [1:0]         req_code [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_op_a[gi] = ReqOpA_DI[gi*C_WIDTH +: C_WIDTH];
            assign req_op_b[gi] = ReqOpB_DI[gi*C_WIDTH +: C_WIDTH];
            assign req_code[gi] = ReqOpCode_DI[2*gi +: 2];
        end
    endgenerate

    logic               grant_any;
    logic               grant_idx;
    logic [C_WIDTH-1:0] sel_a;
    logic [C_WIDTH-1:0] sel_b;
    logic [1:0]         sel_code;
    logic               sel_signed;
    logic               sel_zero;
    logic               lead_ref;
    int                 lead_cnt;
    int                 shift_int;
    logic [1:0]         req_rdy;

    // Pointer only matters under contention; a lone requester always wins.
    assign grant_any  = |ReqVld_SI;
    assign grant_idx  = (ReqVld_SI == 2'b11) ? prio_reg : ReqVld_SI[1];
    assign sel_a      = req_op_a[grant_idx];
    assign sel_b      = req_op_b[grant_idx];
    assign sel_code   = req_code[grant_idx];
    assign sel_signed = sel_code[0];
    assign sel_zero   = (sel_b == '0);
    assign lead_ref   = sel_signed & sel_b[C_WIDTH-1];

    // Run length of leading bits equal to lead_ref; C_WIDTH when every bit matches.
    always_comb begin
        lead_cnt = C_WIDTH;
        for (int i = 0; i < C_WIDTH; i++) begin
            if (sel_b[i] != lead_ref) begin
                lead_cnt = C_WIDTH - 1 - i;
            end
        end
        if (lead_cnt == C_WIDTH) begin
            shift_int = C_WIDTH - 1;
        end else if (sel_signed) begin
            shift_int = lead_cnt - 1;
        end else begin
            shift_int = lead_cnt;
        end
        if (!sel_signed) begin
            shift_int = shift_int + 1;
        end
    end

    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        owner_next = owner_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        res_next   = res_reg;
        shift_next = shift_reg;
        zero_next  = zero_reg;
        sign_next  = sign_reg;
        code_next  = code_reg;
        req_rdy    = 2'b00;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    req_rdy    = grant_idx ? 2'b10 : 2'b01;
                    prio_next  = ~grant_idx;
                    owner_next = grant_idx;
                    op_a_next  = sel_a;
                    op_b_next  = sel_b;
                    code_next  = sel_code;
                    zero_next  = sel_zero;
                    sign_next  = sel_b[C_WIDTH-1] & sel_signed;
                    shift_next = C_LOG_WIDTH'(shift_int);
                    state_next = ISSUE;
`ifdef DIV_ARB_ZERO_BYPASS_EN
                    if (sel_zero) begin
                        res_next   = sel_code[1] ? sel_a : '1;
                        state_next = RESP;
                    end
`endif
                end
            end
            ISSUE: begin
                state_next = BUSY;
            end
            BUSY: begin
                if (Div_OutVld_SI) begin
                    res_next   = Div_Res_DI;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (RspRdy_SI[owner_reg]) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
            owner_reg <= 1'b0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            res_reg   <= '0;
            shift_reg <= '0;
            zero_reg  <= 1'b0;
            sign_reg  <= 1'b0;
            code_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            owner_reg <= owner_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            res_reg   <= res_next;
            shift_reg <= shift_next;
            zero_reg  <= zero_next;
            sign_reg  <= sign_next;
            code_reg  <= code_next;
        end
    end

    // Reset gates the combinational grant so every output reads 0 while held.
    assign ReqRdy_SO        = req_rdy & {2{Rst_RBI}};
    assign RspVld_SO        = (state_reg == RESP) ? (owner_reg ? 2'b10 : 2'b01) : 2'b00;
    assign RspRes_DO        = res_reg;
    assign Busy_SO          = (state_reg != IDLE);
    assign Div_OpA_DO       = op_a_reg;
    assign Div_OpB_DO       = op_b_reg;
    assign Div_OpBShift_DO  = shift_reg;
    assign Div_OpBIsZero_SO = zero_reg;
    assign Div_OpBSign_SO   = sign_reg;
    assign Div_OpCode_SO    = code_reg;
    assign Div_InVld_SO     = (state_reg == ISSUE);
    assign Div_OutRdy_SO    = (state_reg == BUSY);

endmodule
